myo_spi_responder: RTL and testbench

//  SPI slave that sits at the far end of the motor-board frame link (and doubles as a board emulator in sim).

---
 rtl/myo_spi_pkg.sv | 14 +
 rtl/spi_input_sync.sv | 34 +++
 rtl/myo_spi_responder.sv | 173 +++++++++++++++++
 tb/tb_myo_spi_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/myo_spi_pkg.sv
// myo_spi_pkg: shared constants, tx word map indices and FSM state type for the motor-board SPI responder.
package myo_spi_pkg;
    localparam int FRAME_WORDS = 12;
    localparam int WORD_BITS = 16;
    localparam logic [WORD_BITS-1:0] HEADER_WORD = 16'h8000;
    localparam int IDX_POS_HI = 5;
    localparam int IDX_POS_LO = 6;
    localparam int IDX_VELOCITY = 7;
    localparam int IDX_CURRENT = 8;
    localparam int IDX_DISPLACEMENT = 9;
    localparam int IDX_SENSOR1 = 10;
    localparam int IDX_SENSOR2 = 11;
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
endpackage

// File: rtl/spi_input_sync.sv
// spi_input_sync: 2-FF synchronizers for the async SPI pins with rise/fall detection on sck and ss_n.
module spi_input_sync (
    input  logic clock,
    input  logic reset,
    input  logic sck,
    input  logic ss_n,
    input  logic mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic ss_rise,
    output logic ss_fall,
    output logic mosi_sync
);
    logic [2:0] sck_q;
    logic [2:0] ss_q;
    logic [1:0] mosi_q;
    // ss_n history resets low so a pin held low across reset never looks like a fresh frame start
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sck_q  <= '0;
            ss_q   <= '0;
            mosi_q <= '0;
        end else begin
            sck_q  <= {sck_q[1:0], sck};
            ss_q   <= {ss_q[1:0], ss_n};
            mosi_q <= {mosi_q[0], mosi};
        end
    end
    assign sck_rise  = sck_q[1] & ~sck_q[2];
    assign sck_fall  = ~sck_q[1] & sck_q[2];
    assign ss_rise   = ss_q[1] & ~ss_q[2];
    assign ss_fall   = ~ss_q[1] & ss_q[2];
    assign mosi_sync = mosi_q[1];
endmodule

// File: rtl/myo_spi_responder.sv
// myo_spi_responder: SPI mode-0 slave for the motor-board frame; decodes pwm_ref and returns snapshotted status.
// Optional watchdog safe-stop enabled by defining MYO_SPI_WATCHDOG_EN.
module myo_spi_responder #(
    parameter int FRAME_WORDS = myo_spi_pkg::FRAME_WORDS
`ifdef MYO_SPI_WATCHDOG_EN
    , parameter int WATCHDOG_CYCLES = 5000000
`endif
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sck,
    input  logic               ss_n,
    input  logic               mosi,
    output logic               miso,
    input  logic signed [31:0] position,
    input  logic signed [15:0] velocity,
    input  logic signed [15:0] current,
    input  logic signed [15:0] displacement,
    input  logic signed [15:0] sensor1,
    input  logic signed [15:0] sensor2,
    output logic signed [15:0] pwm_ref,
    output logic               pwm_valid,
    output logic               frame_error,
    output logic               busy,
    output logic               timeout
);
    import myo_spi_pkg::*;

    localparam int WC_W = $clog2(FRAME_WORDS + 1);

    state_t                state;
    logic [3:0]            bit_cnt;
    logic [WC_W-1:0]       word_cnt;
    logic [WC_W-1:0]       tx_idx;
    logic [WORD_BITS-1:0]  rx_shift;
    logic [WORD_BITS-1:0]  rx_word;
    logic [WORD_BITS-1:0]  tx_shift;
    logic [WORD_BITS-1:0]  tx_next;
    logic [WORD_BITS-1:0]  w0;
    logic [WORD_BITS-1:0]  w1;
    logic [31:0]           snap_pos;
    logic [WORD_BITS-1:0]  snap_vel;
    logic [WORD_BITS-1:0]  snap_cur;
    logic [WORD_BITS-1:0]  snap_disp;
    logic [WORD_BITS-1:0]  snap_s1;
    logic [WORD_BITS-1:0]  snap_s2;
    logic                  sck_seen;
    logic                  sck_rise;
    logic                  sck_fall;
    logic                  ss_rise;
    logic                  ss_fall;
    logic                  mosi_sync;
    logic                  frame_end;
    logic                  frame_ok;
    logic                  frame_glitch;
    logic                  wd_hit;

    spi_input_sync u_sync (
        .clock     (clock),
        .reset     (reset),
        .sck       (sck),
        .ss_n      (ss_n),
        .mosi      (mosi),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall),
        .ss_rise   (ss_rise),
        .ss_fall   (ss_fall),
        .mosi_sync (mosi_sync)
    );

    assign rx_word      = {rx_shift[WORD_BITS-2:0], mosi_sync};
    assign tx_idx       = word_cnt + 1'b1;
    assign frame_end    = ss_rise && state != IDLE;
    assign frame_ok     = frame_end && int'(word_cnt) == FRAME_WORDS && w0 == HEADER_WORD;
    assign frame_glitch = word_cnt == '0 && !sck_seen;

    always_comb begin
        tx_next = int'(tx_idx) == IDX_POS_HI       ? snap_pos[31:16] :
                  int'(tx_idx) == IDX_POS_LO       ? snap_pos[15:0]  :
                  int'(tx_idx) == IDX_VELOCITY     ? snap_vel        :
                  int'(tx_idx) == IDX_CURRENT      ? snap_cur        :
                  int'(tx_idx) == IDX_DISPLACEMENT ? snap_disp       :
                  int'(tx_idx) == IDX_SENSOR1      ? snap_s1         :
                  int'(tx_idx) == IDX_SENSOR2      ? snap_s2         : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            w0          <= '0;
            w1          <= '0;
            snap_pos    <= '0;
            snap_vel    <= '0;
            snap_cur    <= '0;
            snap_disp   <= '0;
            snap_s1     <= '0;
            snap_s2     <= '0;
            sck_seen    <= 1'b0;
            miso        <= 1'b0;
            pwm_ref     <= '0;
            pwm_valid   <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            pwm_valid   <= frame_ok;
            frame_error <= frame_end && !frame_ok && !frame_glitch;
            pwm_ref     <= frame_ok ? {w1[14], w1[14:0]} : wd_hit ? '0 : pwm_ref;
            if (frame_end) begin
                state <= IDLE;
                busy  <= 1'b0;
                miso  <= 1'b0;
            end else if (state == IDLE) begin
                if (ss_fall) begin
                    state     <= ACTIVE;
                    busy      <= 1'b1;
                    bit_cnt   <= '0;
                    word_cnt  <= '0;
                    sck_seen  <= 1'b0;
                    snap_pos  <= position;
                    snap_vel  <= velocity;
                    snap_cur  <= current;
                    snap_disp <= displacement;
                    snap_s1   <= sensor1;
                    snap_s2   <= sensor2;
                    // tx word 0 is always zero, so its MSB is zero too
                    tx_shift  <= '0;
                    miso      <= 1'b0;
                end
            end else if (state == ACTIVE) begin
                if (sck_rise || sck_fall)
                    sck_seen <= 1'b1;
                if (sck_rise) begin
                    rx_shift <= rx_word;
                    bit_cnt  <= bit_cnt + 1'b1;
                    if (bit_cnt == 4'd15) begin
                        word_cnt <= tx_idx;
                        w0       <= word_cnt == '0 ? rx_word : w0;
                        w1       <= int'(word_cnt) == 1 ? rx_word : w1;
                        tx_shift <= tx_next;
                        miso     <= int'(tx_idx) == FRAME_WORDS ? 1'b0 : tx_next[WORD_BITS-1];
                        state    <= int'(tx_idx) == FRAME_WORDS ? DONE : ACTIVE;
                    end
                // the fall right after a word boundary must keep the freshly loaded MSB on miso
                end else if (sck_fall && bit_cnt != '0) begin
                    tx_shift <= {tx_shift[WORD_BITS-2:0], 1'b0};
                    miso     <= tx_shift[WORD_BITS-2];
                end
            end
        end
    end

`ifdef MYO_SPI_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    assign wd_hit = int'(wd_cnt) == WATCHDOG_CYCLES;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            wd_cnt  <= frame_ok ? '0 : wd_hit ? wd_cnt : wd_cnt + 1'b1;
            timeout <= frame_ok ? 1'b0 : wd_hit ? 1'b1 : timeout;
        end
    end
`else
    assign wd_hit  = 1'b0;
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_myo_spi_responder.sv
// tb_myo_spi_responder: directed SPI master frames with a queued scoreboard checked by event monitors.
module tb_myo_spi_responder;
    localparam int HALF = 80;
    localparam int K_PWM = 0;
    localparam int K_ERR = 1;
    localparam int K_MISO = 2;
`ifdef MYO_SPI_WATCHDOG_EN
    localparam int WD_CYC = 20000;
`endif

    typedef struct {
        int          kind;
        logic [15:0] val;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic sck = 1'b0;
    logic ss_n = 1'b1;
    logic mosi = 1'b0;
    logic miso;
    logic signed [31:0] position = '0;
    logic signed [15:0] velocity = '0;
    logic signed [15:0] current = '0;
    logic signed [15:0] displacement = '0;
    logic signed [15:0] sensor1 = '0;
    logic signed [15:0] sensor2 = '0;
    logic signed [15:0] pwm_ref;
    logic pwm_valid;
    logic frame_error;
    logic busy;
    logic timeout;

    ev_t         exp_q[$];
    logic [15:0] mw[0:15];
    logic [15:0] got_word;
    event        word_ev;
    int          change_at = -1;
    int          checks = 0;
    int          errors = 0;

    myo_spi_responder #(
        .FRAME_WORDS(12)
`ifdef MYO_SPI_WATCHDOG_EN
        , .WATCHDOG_CYCLES(WD_CYC)
`endif
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sck          (sck),
        .ss_n         (ss_n),
        .mosi         (mosi),
        .miso         (miso),
        .position     (position),
        .velocity     (velocity),
        .current      (current),
        .displacement (displacement),
        .sensor1      (sensor1),
        .sensor2      (sensor2),
        .pwm_ref      (pwm_ref),
        .pwm_valid    (pwm_valid),
        .frame_error  (frame_error),
        .busy         (busy),
        .timeout      (timeout)
    );

    always #5 clock = ~clock;

    function automatic void check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void expect_ev(input int kind, input logic [15:0] val, input string name);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event with value %h", name, val);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.val !== val) begin
            errors++;
            $display("FAIL %s: got kind %0d value %h expected kind %0d value %h", name, kind, val, e.kind, e.val);
        end
    endfunction

    always @(negedge clock) begin
        if (pwm_valid)
            expect_ev(K_PWM, pwm_ref, "pwm_valid");
        if (frame_error)
            expect_ev(K_ERR, pwm_ref, "frame_error");
    end

    always @(word_ev)
        expect_ev(K_MISO, got_word, "miso_word");

    function automatic void push(input int kind, input logic [15:0] v);
        exp_q.push_back('{kind, v});
    endfunction

    function automatic void push_status(input int nwords);
        for (int i = 0; i < nwords; i++)
            push(K_MISO, i == 5  ? position[31:16] : i == 6  ? position[15:0] :
                         i == 7  ? velocity        : i == 8  ? current        :
                         i == 9  ? displacement    : i == 10 ? sensor1        :
                         i == 11 ? sensor2         : 16'h0000);
    endfunction

    task automatic spi_frame(input int nwords, input int extra);
        logic [15:0] rx;
        rx = '0;
        ss_n = 1'b0;
        #(HALF);
        check_val("busy_in_frame", {31'd0, busy}, 32'd1);
        for (int w = 0; w < nwords; w++) begin
            for (int b = 15; b >= 0; b--) begin
                mosi = mw[w][b];
                #(HALF);
                rx = {rx[14:0], miso};
                sck = 1'b1;
                #(HALF);
                sck = 1'b0;
            end
            got_word = rx;
            ->word_ev;
            if (w == change_at) begin
                position = 32'h11112222;
                velocity = 16'h7777;
                sensor2 = 16'h5A5A;
            end
        end
        for (int e = 0; e < extra; e++) begin
            mosi = 1'b1;
            #(HALF);
            sck = 1'b1;
            #(HALF);
            sck = 1'b0;
        end
        #(HALF);
        ss_n = 1'b1;
        #(4 * HALF);
        check_val("busy_after_frame", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_miso"}, {31'd0, miso}, 32'd0);
        check_val({tag, "_pwm_ref"}, {16'd0, pwm_ref}, 32'd0);
        check_val({tag, "_pwm_valid"}, {31'd0, pwm_valid}, 32'd0);
        check_val({tag, "_frame_error"}, {31'd0, frame_error}, 32'd0);
        check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_val({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++)
            mw[i] = '0;
        #42;
        check_all_zero("reset");
        reset = 1'b0;
        #100;
        check_all_zero("post_reset");

        mw[0] = 16'h8000;
        mw[1] = 16'h1234;
        push_status(12);
        push(K_PWM, 16'h1234);
        spi_frame(12, 0);

        mw[1] = 16'h7FF0;
        push_status(12);
        push(K_PWM, 16'hFFF0);
        spi_frame(12, 0);

        position = 32'hDEADBEEF;
        velocity = 16'h0102;
        current = 16'h0203;
        displacement = 16'h0304;
        sensor1 = 16'h0405;
        sensor2 = 16'h0607;
        mw[1] = 16'h0100;
        change_at = 4;
        push_status(12);
        push(K_PWM, 16'h0100);
        spi_frame(12, 0);
        change_at = -1;

        mw[0] = 16'h8001;
        mw[1] = 16'h2222;
        push_status(12);
        push(K_ERR, 16'h0100);
        spi_frame(12, 0);

        mw[0] = 16'h8000;
        mw[1] = 16'h3333;
        push_status(7);
        push(K_ERR, 16'h0100);
        spi_frame(7, 5);

        ss_n = 1'b0;
        #(HALF);
        ss_n = 1'b1;
        #(4 * HALF);
        check_val("glitch_pwm_ref", {16'd0, pwm_ref}, 32'h0100);

        mw[1] = 16'h4000;
        mw[12] = 16'hAAAA;
        mw[13] = 16'h5555;
        push_status(14);
        push(K_PWM, 16'hC000);
        spi_frame(14, 0);

        ss_n = 1'b0;
        #(HALF);
        for (int i = 0; i < 20; i++) begin
            mosi = i[0];
            #(HALF);
            sck = 1'b1;
            #(HALF);
            sck = 1'b0;
        end
        reset = 1'b1;
        #30;
        check_all_zero("mid_reset");
        reset = 1'b0;
        #50;
        ss_n = 1'b1;
        #(4 * HALF);
        check_val("after_reset_busy", {31'd0, busy}, 32'd0);
        mw[1] = 16'h0055;
        push_status(12);
        push(K_PWM, 16'h0055);
        spi_frame(12, 0);

`ifdef MYO_SPI_WATCHDOG_EN
        #(WD_CYC * 10 + 500);
        check_val("wd_timeout", {31'd0, timeout}, 32'd1);
        check_val("wd_pwm_safe", {16'd0, pwm_ref}, 32'd0);
        mw[1] = 16'h0077;
        push_status(12);
        push(K_PWM, 16'h0077);
        spi_frame(12, 0);
        check_val("wd_cleared", {31'd0, timeout}, 32'd0);
        check_val("wd_pwm_loaded", {16'd0, pwm_ref}, 32'h0077);
`else
        #2000;
        check_val("no_wd_timeout", {31'd0, timeout}, 32'd0);
        check_val("no_wd_pwm_hold", {16'd0, pwm_ref}, 32'h0055);
`endif
        #200;
        check_val("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
